in_service_register: RTL and testbench
======================================

// Module: in_service_register
// PURPOSE
//  Sits directly downstream of Priority_Resolver. Consumes PriorityID/INTFLAG, raises INT to the CPU and runs
//  the 8086-mode two-pulse INTA sequence. Holds the ISR bits (fed back as IS_status) and last_serviced (fed back
//  for rotation). Sends a clear pulse to the IRR and executes EOI commands from control (normal, AEOI, rotate).
// PARAMETERS
//  NUM_IR      8   interrupt lines; fixed at 8, and the PriorityID/last_serviced widths depend on it
//  SPUR_ID     7   ID latched and returned on a spurious acknowledge
// PORTS
//  clk            in   1  single clock; all state changes on its rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  PriorityID     in   3  winning level from Priority_Resolver
//  INTFLAG        in   1  a level wins resolution (already gated by IS_status)
//  INTA_n         in   1  CPU acknowledge, active low, synchronous to clk
//  AEOI           in   1  automatic EOI mode (ICW4)
//  Rotating_priority in 1 rotate-on-EOI mode; also selects the non-specific EOI search order
//  nonspec_EOI    in   1  one-cycle pulse: non-specific EOI command
//  spec_EOI       in   1  one-cycle pulse: specific EOI command
//  EOI_level      in   3  level for spec_EOI
//  INT            out  1  interrupt request to CPU
//  IS_status      out  8  in-service bits to resolver
//  last_serviced  out  3  lowest-priority reference for rotation
//  clr_IRR        out  8  one-hot one-cycle pulse clearing the acknowledged IRR bit
//  vector_en      out  1  data-bus buffer drives the vector (second INTA low)
//  vector_ID      out  3  level to encode into the vector
//  spurious       out  1  current acknowledge is spurious (held until the sequence ends)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; INT=0, IS_status=0, clr_IRR=0, vector_en=0, vector_ID=0, spurious=0,
//   last_serviced=3'b111 (IR0 highest). Reset mid-sequence aborts it with no IRR clear and no ISR set.
//  INTA edge: inta_fall = prev_INTA_n & ~INTA_n; inta_rise = ~prev_INTA_n & INTA_n (prev registered, reset 1).
//  FSM (registered state):
//   IDLE  : INTFLAG=1 -> PEND and INT=1 from the next cycle.
//   PEND  : INT held. INTFLAG dropping does NOT drop INT. inta_fall -> ACK1.
//   ACK1  : on the entry edge vector_ID<=INTFLAG?PriorityID:SPUR_ID; spurious<=~INTFLAG; INT<=0. If not spurious:
//           IS_status[ID]<=1 and clr_IRR[ID] pulses for exactly 1 cycle. inta_rise -> GAP.
//   GAP   : wait; inta_fall -> ACK2.
//   ACK2  : vector_en=1 while here. On inta_rise -> IDLE; vector_en=0, spurious=0. If AEOI and not spurious,
//           clear IS_status[vector_ID] on that edge (and last_serviced<=vector_ID if Rotating_priority).
//  inta_fall in IDLE (acknowledge with INT never raised): enter ACK1 as spurious.
//  Latency: INTFLAG->INT 1 cycle; INTA fall->IS bit set 1 cycle.
//  EOI (any state):
//   spec_EOI clears IS_status[EOI_level].
//   nonspec_EOI clears the highest-priority set bit: fully nested = lowest index; rotating = first set bit
//    scanning last_serviced+1 upward, modulo 8.
//   In rotating mode the cleared level becomes last_serviced.
//   EOI with ISR empty, or a specific EOI on a clear bit: no change, last_serviced unchanged.
//   spec_EOI and nonspec_EOI in the same cycle: spec_EOI wins.
//  Simultaneous events:
//   EOI clear and ACK1 set in one cycle: apply the clear, then the set (same bit -> ends set).
//   AEOI clear and an EOI in one cycle: both clears apply; last_serviced takes the AEOI level.
//  Nested service: a new sequence may start while IS bits are set; ISR may hold several ones.
// STRUCTURE
//  Shared package pic_pkg: FSM state encoding (IDLE/PEND/ACK1/GAP/ACK2), NUM_IR, SPUR_ID, LAST_SERV_RST=3'b111,
//   function rot_first_set(bits, start) for modulo-8 priority search (also reusable by the resolver).
//  One sub-module: isr_eoi_select (combinational) takes IS_status, last_serviced, Rotating_priority,
//   nonspec_EOI, spec_EOI, EOI_level and returns clear mask[7:0], eoi_level[2:0], eoi_hit.
// TESTING
//  1 Normal: INTFLAG=1, ID=3, two INTA pulses -> INT rises 1 cycle later; IS=8'h08, clr_IRR=8'h08 for 1 cycle,
//    vector_en=1 with vector_ID=3 during the 2nd pulse; nonspec_EOI -> IS=0.
//  2 AEOI+rotate: AEOI=1, Rotating=1, ID=5 acknowledged -> IS=0 after the 2nd INTA rises; last_serviced=5.
//  3 Spurious: INT raised for ID=2, INTFLAG drops before the 1st INTA -> vector_ID=7, spurious=1, IS=0, clr_IRR=0.
//  4 Rotating nonspec EOI: IS=8'h81, last_serviced=6 -> clears bit 7 (IS=8'h01), last_serviced=7.
//  5 Collision: spec_EOI level 4 in the same cycle ACK1 sets bit 4 (IS=8'h10 before) -> IS=8'h10;
//    EOI with IS=0 -> no change.
//  6 Reset mid-GAP: rst_n low -> all outputs at reset values immediately; release, then a fresh sequence completes.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller slice: service sequence
// states, fixed sizing constants and small level/priority helpers.
package pic_pkg;

  localparam int         NUM_IR        = 8;
  localparam logic [2:0] SPUR_ID       = 3'd7;
  localparam logic [2:0] LAST_SERV_RST = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PEND = 3'd1,
    ST_ACK1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK2 = 3'd4
  } isr_state_e;

  // First set bit found scanning upward from start, wrapping modulo 8.
  // Returns start when no bit is set; callers qualify with |bits.
  function automatic logic [2:0] rot_first_set(input logic [7:0] bits,
                                               input logic [2:0] start);
    logic [2:0] result;
    logic [2:0] idx;
    logic       found;
    result = start;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = start + 3'(i);
      if (!found && bits[idx]) begin
        result = idx;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
    return result;
  endfunction

  // One-hot mask for an interrupt level.
  function automatic logic [7:0] level_onehot(input logic [2:0] lvl);
    return 8'd1 << lvl;
  endfunction

endpackage

// File: rtl/isr_eoi_select.sv
// Decodes an EOI command into the in-service bit it clears. A specific EOI
// names its level; a non-specific EOI picks the highest-priority set bit,
// either lowest index (fully nested) or scanning just past last_serviced.
module isr_eoi_select
  import pic_pkg::*;
(
  input  logic [7:0] is_status,
  input  logic [2:0] last_serviced,
  input  logic       rotating_priority,
  input  logic       nonspec_eoi,
  input  logic       spec_eoi,
  input  logic [2:0] eoi_level_req,
  output logic [7:0] clear_mask,
  output logic [2:0] eoi_level,
  output logic       eoi_hit
);

  logic [2:0] search_start_s;

  // Scan origin: lowest index in nested mode, one past the last serviced level when rotating.
  always_comb begin
    search_start_s = 3'd0;
    if (rotating_priority) begin
      search_start_s = last_serviced + 3'd1;
    end else begin
      search_start_s = 3'd0;
    end
  end

  // Select the level to clear; a specific EOI takes precedence over a non-specific one.
  always_comb begin
    eoi_level  = 3'd0;
    eoi_hit    = 1'b0;
    clear_mask = 8'd0;
    if (spec_eoi) begin
      eoi_level = eoi_level_req;
      eoi_hit   = is_status[eoi_level_req];
    end else if (nonspec_eoi) begin
      eoi_level = rot_first_set(is_status, search_start_s);
      eoi_hit   = |is_status;
    end else begin
      eoi_hit   = 1'b0;
    end
    if (eoi_hit) begin
      clear_mask = level_onehot(eoi_level);
    end else begin
      clear_mask = 8'd0;
    end
  end

endmodule

// File: rtl/in_service_register.sv
// In-service register: raises INT for a resolved level, runs the two-pulse
// INTA handshake, tracks in-service bits and the rotation reference, and
// executes normal, automatic and rotating end-of-interrupt clears.
module in_service_register
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        PriorityID,
  input  logic              INTFLAG,
  input  logic              INTA_n,
  input  logic              AEOI,
  input  logic              Rotating_priority,
  input  logic              nonspec_EOI,
  input  logic              spec_EOI,
  input  logic [2:0]        EOI_level,
  output logic              INT,
  output logic [NUM_IR-1:0] IS_status,
  output logic [2:0]        last_serviced,
  output logic [NUM_IR-1:0] clr_IRR,
  output logic              vector_en,
  output logic [2:0]        vector_ID,
  output logic              spurious
);

  isr_state_e state_r, state_nxt_s;
  logic       prev_inta_r;
  logic       inta_fall_s, inta_rise_s;
  logic       int_nxt_s, ven_nxt_s, spur_nxt_s;
  logic [2:0] vid_nxt_s, ls_nxt_s;
  logic [7:0] clr_nxt_s, is_nxt_s, set_mask_s, aeoi_mask_s;
  logic       aeoi_hit_s;
  logic [7:0] eoi_mask_s;
  logic [2:0] eoi_level_s;
  logic       eoi_hit_s;

  assign inta_fall_s = prev_inta_r & ~INTA_n;
  assign inta_rise_s = ~prev_inta_r & INTA_n;

  isr_eoi_select u_eoi_select (
    .is_status         (IS_status),
    .last_serviced     (last_serviced),
    .rotating_priority (Rotating_priority),
    .nonspec_eoi       (nonspec_EOI),
    .spec_eoi          (spec_EOI),
    .eoi_level_req     (EOI_level),
    .clear_mask        (eoi_mask_s),
    .eoi_level         (eoi_level_s),
    .eoi_hit           (eoi_hit_s)
  );

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus the per-transition updates of INT, vector and ISR set/clear requests.
  always_comb begin
    state_nxt_s = state_r;
    int_nxt_s   = INT;
    ven_nxt_s   = vector_en;
    vid_nxt_s   = vector_ID;
    spur_nxt_s  = spurious;
    clr_nxt_s   = 8'd0;
    set_mask_s  = 8'd0;
    aeoi_mask_s = 8'd0;
    aeoi_hit_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (inta_fall_s) begin
          // Acknowledge without a raised request is always spurious.
          state_nxt_s = ST_ACK1;
          vid_nxt_s   = SPUR_ID;
          spur_nxt_s  = 1'b1;
          int_nxt_s   = 1'b0;
        end else if (INTFLAG) begin
          state_nxt_s = ST_PEND;
          int_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (inta_fall_s) begin
          state_nxt_s = ST_ACK1;
          int_nxt_s   = 1'b0;
          spur_nxt_s  = ~INTFLAG;
          if (INTFLAG) begin
            vid_nxt_s  = PriorityID;
            set_mask_s = level_onehot(PriorityID);
            clr_nxt_s  = level_onehot(PriorityID);
          end else begin
            vid_nxt_s  = SPUR_ID;
          end
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_ACK1: begin
        if (inta_rise_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_ACK1;
        end
      end
      ST_GAP: begin
        if (inta_fall_s) begin
          state_nxt_s = ST_ACK2;
          ven_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_ACK2: begin
        if (inta_rise_s) begin
          state_nxt_s = ST_IDLE;
          ven_nxt_s   = 1'b0;
          spur_nxt_s  = 1'b0;
          if (AEOI && !spurious) begin
            aeoi_mask_s = level_onehot(vector_ID);
            aeoi_hit_s  = 1'b1;
          end else begin
            aeoi_hit_s  = 1'b0;
          end
        end else begin
          state_nxt_s = ST_ACK2;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        int_nxt_s   = 1'b0;
        ven_nxt_s   = 1'b0;
        spur_nxt_s  = 1'b0;
      end
    endcase
  end

  // ISR update: all clears first, then the acknowledge set; AEOI level owns the rotation reference.
  always_comb begin
    is_nxt_s = (IS_status & ~eoi_mask_s & ~aeoi_mask_s) | set_mask_s;
    ls_nxt_s = last_serviced;
    if (aeoi_hit_s && Rotating_priority) begin
      ls_nxt_s = vector_ID;
    end else if (eoi_hit_s && Rotating_priority) begin
      ls_nxt_s = eoi_level_s;
    end else begin
      ls_nxt_s = last_serviced;
    end
  end

  // Registered outputs and INTA edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_inta_r   <= 1'b1;
      INT           <= 1'b0;
      IS_status     <= 8'd0;
      last_serviced <= LAST_SERV_RST;
      clr_IRR       <= 8'd0;
      vector_en     <= 1'b0;
      vector_ID     <= 3'd0;
      spurious      <= 1'b0;
    end else begin
      prev_inta_r   <= INTA_n;
      INT           <= int_nxt_s;
      IS_status     <= is_nxt_s;
      last_serviced <= ls_nxt_s;
      clr_IRR       <= clr_nxt_s;
      vector_en     <= ven_nxt_s;
      vector_ID     <= vid_nxt_s;
      spurious      <= spur_nxt_s;
    end
  end

endmodule

// File: tb/tb_in_service_register.sv
// Bench for in_service_register: directed scenarios followed by randomized
// acknowledge/EOI traffic, checked against a level-based ISR model.
module tb_in_service_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] PriorityID;
  logic       INTFLAG, INTA_n, AEOI, Rotating_priority, nonspec_EOI, spec_EOI;
  logic [2:0] EOI_level;
  logic       INT, vector_en, spurious;
  logic [7:0] IS_status, clr_IRR;
  logic [2:0] last_serviced, vector_ID;

  int vectors = 0;
  int miscompares = 0;

  // Expected values
  logic       exp_int, exp_ven, exp_spur;
  logic [7:0] exp_is, exp_clr;
  logic [2:0] exp_vid, exp_ls;

  in_service_register dut (
    .clk (clk), .rst_n (rst_n), .PriorityID (PriorityID), .INTFLAG (INTFLAG),
    .INTA_n (INTA_n), .AEOI (AEOI), .Rotating_priority (Rotating_priority),
    .nonspec_EOI (nonspec_EOI), .spec_EOI (spec_EOI), .EOI_level (EOI_level),
    .INT (INT), .IS_status (IS_status), .last_serviced (last_serviced),
    .clr_IRR (clr_IRR), .vector_en (vector_en), .vector_ID (vector_ID),
    .spurious (spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".INT"},       8'(INT),           8'(exp_int));
    chk({tag, ".IS"},        IS_status,         exp_is);
    chk({tag, ".clr_IRR"},   clr_IRR,           exp_clr);
    chk({tag, ".vector_en"}, 8'(vector_en),     8'(exp_ven));
    chk({tag, ".vector_ID"}, 8'(vector_ID),     8'(exp_vid));
    chk({tag, ".spurious"},  8'(spurious),      8'(exp_spur));
    chk({tag, ".last_serv"}, 8'(last_serviced), 8'(exp_ls));
  endtask

  function automatic void model_reset();
    exp_int = 1'b0; exp_is = 8'h00; exp_clr = 8'h00; exp_ven = 1'b0;
    exp_vid = 3'd0; exp_spur = 1'b0; exp_ls = 3'd7;
  endfunction

  // EOI rule model: specific wins; non-specific picks highest priority set level.
  function automatic void model_eoi(input bit sp, input bit ns, input int lvl);
    int tgt;
    int c;
    tgt = -1;
    if (sp) begin
      if (exp_is[lvl]) tgt = lvl;
    end else if (ns) begin
      for (int k = 0; k < 8; k++) begin
        if (Rotating_priority) c = (int'(exp_ls) + 1 + k) % 8;
        else c = k;
        if (tgt < 0 && exp_is[c]) tgt = c;
      end
    end
    if (tgt >= 0) begin
      exp_is[tgt] = 1'b0;
      if (Rotating_priority) exp_ls = 3'(tgt);
    end
  endfunction

  // kind: 0 none, 1 specific, 2 non-specific, 3 both
  task automatic drive_eoi(input int kind, input int lvl);
    spec_EOI    = (kind == 1 || kind == 3);
    nonspec_EOI = (kind == 2 || kind == 3);
    EOI_level   = 3'(lvl);
    model_eoi(kind == 1 || kind == 3, kind == 2 || kind == 3, lvl);
  endtask

  task automatic release_eoi();
    spec_EOI = 1'b0; nonspec_EOI = 1'b0;
  endtask

  task automatic do_eoi(input int kind, input int lvl);
    drive_eoi(kind, lvl);
    tick();
    release_eoi();
    chk_all("eoi");
  endtask

  // Full two-pulse acknowledge. idle: INTA with no request; drop: INTFLAG falls while pending.
  // ck/cl: EOI on the first-INTA edge; ek/el: EOI on the final INTA rise.
  task automatic do_ack(input int id, input bit idle, input bit drop,
                        input int ck, input int cl, input int ek, input int el);
    bit sp;
    sp = idle || drop;
    if (!idle) begin
      INTFLAG = 1'b1; PriorityID = 3'(id);
      chk("pre_req.INT", 8'(INT), 8'h00);
      tick();
      exp_int = 1'b1;
      chk_all("req");
      if (drop) begin
        INTFLAG = 1'b0;
        tick();
        chk_all("pend_drop");
      end
    end
    INTA_n = 1'b0;
    drive_eoi(ck, cl);
    tick();
    release_eoi();
    INTFLAG = 1'b0;
    exp_int  = 1'b0;
    exp_spur = sp;
    exp_vid  = sp ? 3'd7 : 3'(id);
    if (!sp) begin
      exp_is[id] = 1'b1;
      exp_clr = 8'd1 << id;
    end
    chk_all("ack1");
    tick();
    exp_clr = 8'h00;
    chk_all("ack1_hold");
    INTA_n = 1'b1;
    tick();
    chk_all("gap");
    INTA_n = 1'b0;
    tick();
    exp_ven = 1'b1;
    chk_all("ack2");
    INTA_n = 1'b1;
    drive_eoi(ek, el);
    tick();
    release_eoi();
    exp_ven = 1'b0;
    exp_spur = 1'b0;
    if (AEOI && !sp) begin
      exp_is[exp_vid] = 1'b0;
      if (Rotating_priority) exp_ls = exp_vid;
    end
    chk_all("ack_end");
  endtask

  initial begin
    rst_n = 1'b0; PriorityID = 3'd0; INTFLAG = 1'b0; INTA_n = 1'b1; AEOI = 1'b0;
    Rotating_priority = 1'b0; nonspec_EOI = 1'b0; spec_EOI = 1'b0; EOI_level = 3'd0;
    model_reset();
    #12;
    chk_all("reset");
    rst_n = 1'b1;

    // 1 normal sequence, then non-specific EOI
    do_ack(3, 0, 0, 0, 0, 0, 0);
    chk("t1.IS", IS_status, 8'h08);
    do_eoi(2, 0);
    chk("t1.IS_after_eoi", IS_status, 8'h00);

    // 2 AEOI with rotation
    AEOI = 1'b1; Rotating_priority = 1'b1;
    do_ack(5, 0, 0, 0, 0, 0, 0);
    chk("t2.last_serv", 8'(last_serviced), 8'h05);

    // 3 spurious: request withdrawn before acknowledge
    AEOI = 1'b0; Rotating_priority = 1'b0;
    do_ack(2, 0, 1, 0, 0, 0, 0);

    // 4 rotating non-specific EOI from last_serviced=6 with IS=81
    AEOI = 1'b1; Rotating_priority = 1'b1;
    do_ack(6, 0, 0, 0, 0, 0, 0);
    AEOI = 1'b0;
    do_ack(7, 0, 0, 0, 0, 0, 0);
    do_ack(0, 0, 0, 0, 0, 0, 0);
    chk("t4.IS_before", IS_status, 8'h81);
    do_eoi(2, 0);
    chk("t4.IS", IS_status, 8'h01);
    chk("t4.last_serv", 8'(last_serviced), 8'h07);
    do_eoi(2, 0);

    // 5 collision of specific EOI with the acknowledge set, then EOIs on empty/clear bits
    Rotating_priority = 1'b0;
    do_ack(4, 0, 0, 0, 0, 0, 0);
    do_ack(4, 0, 0, 1, 4, 0, 0);
    chk("t5.IS", IS_status, 8'h10);
    do_eoi(1, 4);
    do_eoi(2, 0);
    do_eoi(1, 3);

    // spurious acknowledge straight from idle
    do_ack(0, 1, 0, 0, 0, 0, 0);

    // 6 reset while waiting between INTA pulses
    INTFLAG = 1'b1; PriorityID = 3'd1;
    tick();
    INTA_n = 1'b0;
    tick();
    INTFLAG = 1'b0; INTA_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst_gap");
    #2;
    rst_n = 1'b1;
    do_ack(1, 0, 0, 0, 0, 0, 0);
    do_eoi(2, 0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      AEOI = 1'($urandom_range(0, 1));
      Rotating_priority = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      do_ack($urandom_range(0, 7), r == 0, r == 1,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 7),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom_range(0, 7));
      for (int e = 0; e < $urandom_range(0, 2); e++) begin
        do_eoi($urandom_range(1, 3), $urandom_range(0, 7));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
